// File: rtl/framebuffer_access_scheduler_pkg.sv
// Shared types and geometry for the framebuffer access scheduler.
// Line geometry is fixed here so that interface and datapath widths agree.
package framebuffer_access_scheduler_pkg;

    localparam int ACTIVE_H_PIXELS = 640;
    localparam int TOTAL_PIXELS    = 800;
    localparam int ACTIVE_LINES    = 480;
    localparam int TOTAL_LINES     = 525;
    localparam int PIXELS_PER_WORD = 4;
    localparam int LINE_WORDS      = ACTIVE_H_PIXELS / PIXELS_PER_WORD;
    localparam int ADDR_W          = 17;
    localparam int DATA_W          = 32;
    localparam int SX_W            = $clog2(TOTAL_PIXELS);
    localparam int SY_W            = $clog2(TOTAL_LINES);
    localparam int IDX_W           = $clog2(LINE_WORDS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic              req;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_cmd_t;

endpackage

// File: rtl/framebuffer_access_scheduler_if.sv
// Bundle of timing, writer, RAM and line-buffer signals around the scheduler.
// slave is the scheduler's view, master the surrounding system's view.
interface framebuffer_access_scheduler_if;
    import framebuffer_access_scheduler_pkg::*;

    logic [SX_W-1:0]   i_sx;
    logic [SY_W-1:0]   i_sy;
    logic              i_wr_valid;
    logic              o_wr_ready;
    logic [ADDR_W-1:0] i_wr_addr;
    logic [DATA_W-1:0] i_wr_data;
    logic              o_mem_req;
    logic              o_mem_we;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [DATA_W-1:0] o_mem_wdata;
    logic [DATA_W-1:0] i_mem_rdata;
    logic              o_lb_we;
    logic              o_lb_bank;
    logic [IDX_W-1:0]  o_lb_addr;
    logic [DATA_W-1:0] o_lb_wdata;
    logic              o_busy;
    logic              o_underrun;
    logic              i_underrun_clr;

    modport slave (
        input  i_sx, i_sy, i_wr_valid, i_wr_addr, i_wr_data, i_mem_rdata, i_underrun_clr,
        output o_wr_ready, o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata,
               o_lb_we, o_lb_bank, o_lb_addr, o_lb_wdata, o_busy, o_underrun
    );

    modport master (
        output i_sx, i_sy, i_wr_valid, i_wr_addr, i_wr_data, i_mem_rdata, i_underrun_clr,
        input  o_wr_ready, o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata,
               o_lb_we, o_lb_bank, o_lb_addr, o_lb_wdata, o_busy, o_underrun
    );

endinterface

// File: rtl/framebuffer_access_scheduler_rd_return_tracker.sv
// Follows reads from the RAM port to their data return: a valid+word-index
// shift pipe RD_LATENCY deep; flush drops everything in flight, including the entering read.
module rd_return_tracker
    import framebuffer_access_scheduler_pkg::*;
#(
    parameter int RD_LATENCY = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [IDX_W-1:0] idx_i,
    output logic             lb_we_o,
    output logic [IDX_W-1:0] lb_addr_o
);

    logic [RD_LATENCY:1]            vld_pipe_q;
    logic [RD_LATENCY:1][IDX_W-1:0] idx_pipe_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_pipe_q <= '0;
            idx_pipe_q <= '0;
        end else begin
            vld_pipe_q[1] <= push_i && !flush_i;
            idx_pipe_q[1] <= idx_i;
            for (int s = 2; s <= RD_LATENCY; s++) begin
                vld_pipe_q[s] <= vld_pipe_q[s-1] && !flush_i;
                idx_pipe_q[s] <= idx_pipe_q[s-1];
            end
        end
    end

    assign lb_we_o   = vld_pipe_q[RD_LATENCY];
    assign lb_addr_o = idx_pipe_q[RD_LATENCY];

endmodule

// File: rtl/framebuffer_access_scheduler.sv
// Arbitrates the single-port framebuffer between hblank line prefetch and the drawing writer.
// Define FAIR_SLOT_EN to give the writer one slot after every FAIR_PERIOD prefetch reads.
module framebuffer_access_scheduler
    import framebuffer_access_scheduler_pkg::*;
#(
    parameter int RD_LATENCY  = 2,
    parameter int FB_BASE     = 0,
    parameter int FAIR_PERIOD = 8
) (
    input logic                           i_clk_pxl,
    input logic                           i_reset,
    framebuffer_access_scheduler_if.slave bus
);

    if (LINE_WORDS * PIXELS_PER_WORD != ACTIVE_H_PIXELS) begin : g_bad_line
        $error("ACTIVE_H_PIXELS must be a multiple of PIXELS_PER_WORD");
    end
    if (RD_LATENCY < 1 || FAIR_PERIOD < 1) begin : g_bad_param
        $error("RD_LATENCY and FAIR_PERIOD must be at least 1");
    end

    fetch_state_t      state_q, state_d;
    mem_cmd_t          cmd_q, cmd_d;
    logic [IDX_W-1:0]  idx_q, port_idx_q, lb_addr;
    logic [ADDR_W-1:0] line_addr_q;
    logic [SY_W-1:0]   tgt_q, trig_tgt;
    logic              underrun_q, trig, wr_ready, rd_grant, fetch_last, fetch_exit;
    logic              slot, issued, lb_we, ret_last, urun_set;

    assign trig = (bus.i_sx == SX_W'(ACTIVE_H_PIXELS)) &&
                  ((bus.i_sy < SY_W'(ACTIVE_LINES - 1)) || (bus.i_sy == SY_W'(TOTAL_LINES - 1)));
    assign trig_tgt   = (bus.i_sy == SY_W'(TOTAL_LINES - 1)) ? '0 : bus.i_sy + SY_W'(1);
    assign fetch_last = rd_grant && (idx_q == IDX_W'(LINE_WORDS - 1));
    assign ret_last   = lb_we && (lb_addr == IDX_W'(LINE_WORDS - 1));

`ifdef FAIR_SLOT_EN
    localparam int FC_W = $clog2(FAIR_PERIOD + 1);
    logic [FC_W-1:0] fair_cnt_q;
    logic            issued_q;

    assign slot   = (state_q == FETCH) && (fair_cnt_q == FC_W'(FAIR_PERIOD));
    assign issued = issued_q;
    // Leave FETCH after the trailing slot if the last read filled a period.
    assign fetch_exit = (slot && issued_q) || (fetch_last && fair_cnt_q != FC_W'(FAIR_PERIOD - 1));

    always_ff @(posedge i_clk_pxl or posedge i_reset) begin
        if (i_reset) begin
            fair_cnt_q <= '0;
            issued_q   <= 1'b0;
        end else if (trig) begin
            fair_cnt_q <= '0;
            issued_q   <= 1'b0;
        end else begin
            if (slot)          fair_cnt_q <= '0;
            else if (rd_grant) fair_cnt_q <= fair_cnt_q + FC_W'(1);
            if (fetch_last)    issued_q   <= 1'b1;
        end
    end
`else
    assign slot       = 1'b0;
    assign issued     = 1'b0;
    assign fetch_exit = fetch_last;
`endif

    always_ff @(posedge i_clk_pxl or posedge i_reset) begin
        if (i_reset) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // A trigger from any state (re)starts the fetch for the new line.
    always_comb begin
        state_d = state_q;
        if (trig) begin
            state_d = FETCH;
        end else begin
            case (state_q)
                FETCH:   if (fetch_exit) state_d = WAIT;
                WAIT:    if (ret_last)   state_d = IDLE;
                default: ;
            endcase
        end
    end

    always_comb begin
        wr_ready = 1'b0;
        cmd_d    = '0;
        if (!i_reset) wr_ready = (state_q != FETCH) || slot;
        rd_grant = (state_q == FETCH) && !trig && !slot && !issued;
        if (rd_grant) begin
            cmd_d.req  = 1'b1;
            cmd_d.addr = line_addr_q + ADDR_W'(idx_q);
        end else if (bus.i_wr_valid && wr_ready) begin
            cmd_d.req   = 1'b1;
            cmd_d.we    = 1'b1;
            cmd_d.addr  = bus.i_wr_addr;
            cmd_d.wdata = bus.i_wr_data;
        end
    end

    assign urun_set = (state_q != IDLE) &&
                      (trig || (bus.i_sx == '0 && bus.i_sy == tgt_q));

    always_ff @(posedge i_clk_pxl or posedge i_reset) begin
        if (i_reset) begin
            cmd_q       <= '0;
            port_idx_q  <= '0;
            idx_q       <= '0;
            line_addr_q <= ADDR_W'(FB_BASE);
            tgt_q       <= '0;
            underrun_q  <= 1'b0;
        end else begin
            cmd_q      <= cmd_d;
            port_idx_q <= idx_q;
            if (trig) begin
                idx_q <= '0;
                tgt_q <= trig_tgt;
                // Lines are fetched in order, so the base only ever steps or wraps.
                line_addr_q <= (trig_tgt == '0) ? ADDR_W'(FB_BASE)
                                                : line_addr_q + ADDR_W'(LINE_WORDS);
            end else if (rd_grant && idx_q != IDX_W'(LINE_WORDS - 1)) begin
                idx_q <= idx_q + IDX_W'(1);
            end
            if (urun_set)                underrun_q <= 1'b1;
            else if (bus.i_underrun_clr) underrun_q <= 1'b0;
        end
    end

    rd_return_tracker #(.RD_LATENCY(RD_LATENCY)) u_ret (
        .clk_i     (i_clk_pxl),
        .rst_i     (i_reset),
        .flush_i   (trig),
        .push_i    (cmd_q.req && !cmd_q.we),
        .idx_i     (port_idx_q),
        .lb_we_o   (lb_we),
        .lb_addr_o (lb_addr)
    );

    assign bus.o_wr_ready  = wr_ready;
    assign bus.o_mem_req   = cmd_q.req;
    assign bus.o_mem_we    = cmd_q.we;
    assign bus.o_mem_addr  = cmd_q.addr;
    assign bus.o_mem_wdata = cmd_q.wdata;
    assign bus.o_lb_we     = lb_we;
    assign bus.o_lb_bank   = tgt_q[0];
    assign bus.o_lb_addr   = lb_addr;
    assign bus.o_lb_wdata  = lb_we ? bus.i_mem_rdata : '0;
    assign bus.o_busy      = (state_q != IDLE);
    assign bus.o_underrun  = underrun_q;

endmodule

// File: tb/tb_framebuffer_access_scheduler.sv
// Randomized bench: per-cycle checks of the RAM port, line-buffer strobes, ready, busy
// and underrun against a phase-based model of the line fetch.
module tb_framebuffer_access_scheduler;
    import framebuffer_access_scheduler_pkg::*;

    localparam int RL = 2;
    localparam int FP = 8;
`ifdef FAIR_SLOT_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif
    localparam int FETCH_CYC = FAIR ? LINE_WORDS + LINE_WORDS / FP : LINE_WORDS;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    framebuffer_access_scheduler_if bus();

    framebuffer_access_scheduler #(.RD_LATENCY(RL), .FB_BASE(0), .FAIR_PERIOD(FP)) dut (
        .i_clk_pxl (clk),
        .i_reset   (rst),
        .bus       (bus)
    );

    int vectors = 0, miscompares = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Model: everything follows from the phase since the latest trigger.
    int cyc = 0, t0 = -100000, tgt = 0;
    bit uf = 0, pend_w = 0;
    logic [ADDR_W-1:0] pend_a;
    logic [DATA_W-1:0] pend_d;

    function automatic bit m_fetch(input int p);
        return p >= 1 && p <= FETCH_CYC;
    endfunction
    function automatic bit m_slot(input int p);
        return FAIR && m_fetch(p) && (p % (FP + 1) == 0);
    endfunction
    function automatic bit m_busy(input int p);
        return p >= 1 && p <= FETCH_CYC + 1 + RL;
    endfunction
    function automatic bit m_rd(input int p, output int k);
        k = FAIR ? (p - 1) - (p - 1) / (FP + 1) : p - 1;
        return m_fetch(p) && !m_slot(p);
    endfunction

    task automatic quiet();
        bus.i_sx = SX_W'(700); bus.i_sy = '0; bus.i_wr_valid = 1'b0;
        bus.i_wr_addr = '0; bus.i_wr_data = '0; bus.i_underrun_clr = 1'b0;
        bus.i_mem_rdata = 32'hA5A5_5A5A;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_req"},     bus.o_mem_req,   0);
        chk({tag, "_we"},      bus.o_mem_we,    0);
        chk({tag, "_addr"},    bus.o_mem_addr,  0);
        chk({tag, "_wdata"},   bus.o_mem_wdata, 0);
        chk({tag, "_lbwe"},    bus.o_lb_we,     0);
        chk({tag, "_bank"},    bus.o_lb_bank,   0);
        chk({tag, "_lbaddr"},  bus.o_lb_addr,   0);
        chk({tag, "_lbdata"},  bus.o_lb_wdata,  0);
        chk({tag, "_busy"},    bus.o_busy,      0);
        chk({tag, "_urun"},    bus.o_underrun,  0);
        chk({tag, "_wrready"}, bus.o_wr_ready,  0);
    endtask

    task automatic step(input int sx, input int sy, input bit wv, input bit clr);
        int p, k, ntgt;
        bit rdy, bz, trg;
        logic [ADDR_W-1:0] wa;
        logic [DATA_W-1:0] wd, rdv;
        @(posedge clk); #1;
        wa = ADDR_W'($urandom); wd = $urandom; rdv = $urandom;
        bus.i_sx = SX_W'(sx); bus.i_sy = SY_W'(sy); bus.i_wr_valid = wv;
        bus.i_wr_addr = wa; bus.i_wr_data = wd; bus.i_mem_rdata = rdv;
        bus.i_underrun_clr = clr;
        @(negedge clk);
        p   = cyc - t0;
        bz  = m_busy(p);
        rdy = !m_fetch(p) || m_slot(p);
        chk("busy", bus.o_busy, bz);
        chk("wr_ready", bus.o_wr_ready, rdy);
        chk("underrun", bus.o_underrun, uf);
        if (m_rd(p - 1, k)) begin
            chk("rd_req", bus.o_mem_req, 1);
            chk("rd_we", bus.o_mem_we, 0);
            chk("rd_addr", bus.o_mem_addr, tgt * LINE_WORDS + k);
        end else if (pend_w) begin
            chk("wr_req", bus.o_mem_req, 1);
            chk("wr_we", bus.o_mem_we, 1);
            chk("wr_addr", bus.o_mem_addr, pend_a);
            chk("wr_data", bus.o_mem_wdata, pend_d);
        end else begin
            chk("req_idle", bus.o_mem_req, 0);
        end
        if (m_rd(p - 1 - RL, k)) begin
            chk("lb_we", bus.o_lb_we, 1);
            chk("lb_addr", bus.o_lb_addr, k);
            chk("lb_data", bus.o_lb_wdata, rdv);
        end else begin
            chk("lb_we_idle", bus.o_lb_we, 0);
        end
        chk("lb_bank", bus.o_lb_bank, tgt % 2);
        pend_w = wv && rdy; pend_a = wa; pend_d = wd;
        trg  = (sx == ACTIVE_H_PIXELS) && (sy < ACTIVE_LINES - 1 || sy == TOTAL_LINES - 1);
        ntgt = (sy == TOTAL_LINES - 1) ? 0 : sy + 1;
        if (bz && (trg || (sx == 0 && sy == tgt))) uf = 1'b1;
        else if (clr)                              uf = 1'b0;
        if (trg) begin t0 = cyc; tgt = ntgt; end
        cyc++;
    endtask

    task automatic line(input int sy, input int n, input int dl_at, input int ab_at, input int ab_sy);
        int tg;
        tg = (sy == TOTAL_LINES - 1) ? 0 : sy + 1;
        for (int i = 0; i < n; i++) begin
            int sx, syv;
            bit clr;
            sx  = ($urandom % 2 != 0) ? $urandom_range(1, 639) : $urandom_range(641, 799);
            if ($urandom % 40 == 0) sx = 0;
            syv = sy;
            clr = ($urandom % 24 == 0);
            if (i == 0) sx = ACTIVE_H_PIXELS;
            if (i == dl_at) begin sx = 0; syv = tg; clr = 1'b1; end
            if (dl_at >= 0 && i == dl_at + 40) clr = 1'b1;
            if (i == ab_at) begin sx = ACTIVE_H_PIXELS; syv = ab_sy; end
            step(sx, syv, $urandom % 3 != 0, clr);
        end
    endtask

    task automatic reset_mid();
        @(posedge clk); #2;
        rst = 1'b1;
        #1 chk_zero("rst_mid");
        quiet();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        t0 = -100000; tgt = 0; uf = 1'b0; pend_w = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        quiet();
        repeat (3) @(posedge clk);
        #1 chk_zero("rst_init");
        rst = 1'b0;
        for (int l = 0; l < 12; l++) line(l, 166 + $urandom_range(0, 20), -1, -1, 0);
        line(12, 200, 50, -1, 0);
        line(13, 300, -1, 80, 14);
        line(15, 340, -1, 162, 16);
        for (int i = 0; i < 6; i++) step(ACTIVE_H_PIXELS, ACTIVE_LINES - 1, 1'b0, 1'b0);
        line(TOTAL_LINES - 1, 180, -1, -1, 0);
        line(0, 60, -1, -1, 0);
        reset_mid();
        line(TOTAL_LINES - 1, 180, -1, -1, 0);
        line(0, 180, -1, -1, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
